// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to the transmitter and
// receiver) and the default bit-rate divider.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  // State encodings, fixed so the transmitter and receiver agree on them.
  localparam uart_state_t IDLE      = 3'd0;
  localparam uart_state_t START     = 3'd1;
  localparam uart_state_t DATA      = 3'd2;
  localparam uart_state_t STOP      = 3'd3;
  localparam uart_state_t CLEANUP   = 3'd4;
  localparam uart_state_t WAIT_IDLE = 3'd5;

  // Clocks per serial bit when the parent does not override it.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level. Both flops reset to
// RESET_VAL so an idle-high line does not look like a falling edge at reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the line, qualifies the start bit at
// half a bit period, then samples each data bit and the stop bit one full
// bit period apart so every sample lands near mid-bit.
//
// Output handshake: o_RX_DV is a valid-only strobe with no ready. It is high
// for exactly one cycle while o_RX_Byte holds the new byte; the consumer has
// until the next good frame completes to take o_RX_Byte. o_RX_Frame_Err is a
// separate one-cycle strobe and never coincides with o_RX_DV.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active,
  output logic [2:0] o_State
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_s;

  uart_state_t      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       byte_q,    byte_d;
  logic             dv_q,      dv_d;
  logic             err_q,     err_d;
  logic             active_q,  active_d;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (i_Clock),
    .rst_ni (i_Reset_n),
    .d_i    (i_RX_Serial),
    .q_o    (rx_s)
  );

  // Next-state logic: the strobes default low so they last one cycle only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    active_d  = active_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d  = DATA;
            active_d = 1'b1;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            // Bad stop bit: keep the previous good byte and wait for idle so
            // a long break yields a single error.
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      active_q  <= active_d;
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = err_q;
  assign o_RX_Active    = active_q;
  assign o_State        = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at the default 217 clocks/bit for the
// directed frames, one at 4 clocks/bit for exact timing and random traffic.
module tb_uart_rx;

  localparam int CPB_A  = 217;
  localparam int CPB_B  = 4;
  localparam int HALF_A = CPB_A / 2;
  localparam int HALF_B = CPB_B / 2;
  // A pin fall driven at the negedge after edge p is first seen by IDLE at
  // edge p+3 (cycle 0); the strobe is then high in the period after edge
  // p+3+HALF+9*CPB, i.e. visible at that negedge.
  localparam int LAT_A  = 3 + HALF_A + 9 * CPB_A;
  localparam int LAT_B  = 3 + HALF_B + 9 * CPB_B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  logic rx_a, rx_b;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       dv_a, err_a, act_a, dv_b, err_b, act_b;
  logic [7:0] byte_a, byte_b;
  logic [2:0] st_a, st_b;

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n_a), .i_RX_Serial(rx_a),
    .o_RX_DV(dv_a), .o_RX_Byte(byte_a), .o_RX_Frame_Err(err_a),
    .o_RX_Active(act_a), .o_State(st_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n_b), .i_RX_Serial(rx_b),
    .o_RX_DV(dv_b), .o_RX_Byte(byte_b), .o_RX_Frame_Err(err_b),
    .o_RX_Active(act_b), .o_State(st_b)
  );

  // ---------------- monitors (append-only) ----------------
  int         dv_cnt_a = 0, err_cnt_a = 0, act_cnt_a = 0, viol_a = 0, last_dv_cyc_a = 0;
  int         dv_cnt_b = 0, err_cnt_b = 0, viol_b = 0, last_dv_cyc_b = 0;
  logic       dv_prev_a = 1'b0, err_prev_a = 1'b0, dv_prev_b = 1'b0, err_prev_b = 1'b0;
  logic [7:0] got_a_q[$];
  int         got_a_cyc_q[$];
  logic [7:0] got_b_q[$];

  always @(negedge clk) begin
    if (rst_n_a) begin
      if (dv_a) begin
        dv_cnt_a++;
        got_a_q.push_back(byte_a);
        got_a_cyc_q.push_back(cyc);
        last_dv_cyc_a = cyc;
      end
      if (err_a) err_cnt_a++;
      if (act_a) act_cnt_a++;
      if ((dv_a && err_a) || (dv_a && dv_prev_a) || (err_a && err_prev_a)) viol_a++;
    end
    dv_prev_a  = dv_a;
    err_prev_a = err_a;
  end

  always @(negedge clk) begin
    if (rst_n_b) begin
      if (dv_b) begin
        dv_cnt_b++;
        got_b_q.push_back(byte_b);
        last_dv_cyc_b = cyc;
      end
      if (err_b) err_cnt_b++;
      if ((dv_b && err_b) || (dv_b && dv_prev_b) || (err_b && err_prev_b)) viol_b++;
    end
    dv_prev_b  = dv_b;
    err_prev_b = err_b;
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] got_a_at(input int idx);
    if (idx < got_a_q.size()) return {24'd0, got_a_q[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] got_a_cyc_at(input int idx);
    if (idx < got_a_cyc_q.size()) return got_a_cyc_q[idx];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] got_b_at(input int idx);
    if (idx < got_b_q.size()) return {24'd0, got_b_q[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  // ---------------- driver tasks (start and end on a negedge) ----------------
  int fall_cyc[2];

  task automatic drive_line(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // frame[0] is the start bit, frame[8:1] data LSB first, frame[9] stop bit.
  task automatic send_bits(input bit which, input logic [9:0] frame, input int nbits, input int cpb);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) fall_cyc[which] = cyc;
      drive_line(which, frame[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic stop, input int cpb);
    send_bits(which, {stop, d, 1'b0}, 10, cpb);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_dv;
    logic       exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       vecs[7];
  int         b_dv, b_err, b_act, rd;
  logic [9:0] fr;
  logic [7:0] d, last_good, e;
  logic       good;
  logic [7:0] exp_q[$];
  int         exp_err, k;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
    vecs[5] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'h80};
    vecs[6] = '{8'h34, 1'b1, 1'b1, 1'b0, 8'h34};

    rst_n_a = 1'b0; rst_n_b = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    idle_clks(3);

    // Reset state on both instances.
    check("rst_a dv",     dv_a,   0);
    check("rst_a err",    err_a,  0);
    check("rst_a active", act_a,  0);
    check("rst_a byte",   byte_a, 0);
    check("rst_a state",  st_a,   0);
    check("rst_b dv",     dv_b,   0);
    check("rst_b byte",   byte_b, 0);
    check("rst_b state",  st_b,   0);

    rst_n_a = 1'b1; rst_n_b = 1'b1;
    idle_clks(5);
    check("post_rst_a state", st_a, 0);

    // Table: good frames, one framing error with a long break, recovery.
    for (int i = 0; i < 7; i++) begin
      b_dv  = dv_cnt_a;
      b_err = err_cnt_a;
      send_frame(0, vecs[i].data, vecs[i].stop, CPB_A);
      if (!vecs[i].stop) begin
        idle_clks(3000);
        drive_line(0, 1'b1);
      end
      idle_clks(CPB_A);
      check($sformatf("vec%0d dv_count", i),  dv_cnt_a - b_dv,   vecs[i].exp_dv);
      check($sformatf("vec%0d err_count", i), err_cnt_a - b_err, vecs[i].exp_err);
      check($sformatf("vec%0d byte", i),      byte_a,            vecs[i].exp_byte);
      check($sformatf("vec%0d active", i),    act_a,             0);
      check($sformatf("vec%0d state", i),     st_a,              0);
      if (vecs[i].exp_dv)
        check($sformatf("vec%0d latency", i), last_dv_cyc_a - fall_cyc[0], LAT_A);
    end

    // Back-to-back frames with no idle between stop and next start.
    rd   = got_a_q.size();
    b_dv = dv_cnt_a;
    send_frame(0, 8'h55, 1'b1, CPB_A);
    send_frame(0, 8'h3C, 1'b1, CPB_A);
    idle_clks(CPB_A);
    check("b2b dv_count", dv_cnt_a - b_dv, 2);
    check("b2b byte0",    got_a_at(rd),     8'h55);
    check("b2b byte1",    got_a_at(rd + 1), 8'h3C);
    check("b2b spacing",  got_a_cyc_at(rd + 1) - got_a_cyc_at(rd), 10 * CPB_A);

    // Glitch shorter than half a bit.
    b_dv  = dv_cnt_a;
    b_err = err_cnt_a;
    b_act = act_cnt_a;
    drive_line(0, 1'b0);
    idle_clks(50);
    check("glitch in_start", st_a, 1);
    drive_line(0, 1'b1);
    idle_clks(300);
    check("glitch active_seen", act_cnt_a - b_act, 0);
    check("glitch dv_count",    dv_cnt_a - b_dv,   0);
    check("glitch err_count",   err_cnt_a - b_err, 0);
    check("glitch state",       st_a,              0);
    check("glitch byte_kept",   byte_a,            8'h3C);

    // Reset during data bit 4.
    fr = {1'b1, 8'h5A, 1'b0};
    send_bits(0, fr, 5, CPB_A);
    drive_line(0, fr[5]);
    idle_clks(100);
    check("midrst active_before", act_a, 1);
    check("midrst state_before",  st_a,  2);
    rst_n_a = 1'b0;
    #1;
    check("midrst byte",   byte_a, 0);
    check("midrst active", act_a,  0);
    check("midrst dv",     dv_a,   0);
    check("midrst err",    err_a,  0);
    check("midrst state",  st_a,   0);
    drive_line(0, 1'b1);
    idle_clks(5);
    rst_n_a = 1'b1;
    idle_clks(2 * CPB_A);
    b_dv  = dv_cnt_a;
    b_err = err_cnt_a;
    send_frame(0, 8'hC3, 1'b1, CPB_A);
    idle_clks(CPB_A);
    check("after_rst dv_count",  dv_cnt_a - b_dv,   1);
    check("after_rst err_count", err_cnt_a - b_err, 0);
    check("after_rst byte",      byte_a,            8'hC3);
    check("after_rst latency",   last_dv_cyc_a - fall_cyc[0], LAT_A);

    // Exact timing at 4 clocks per bit.
    b_dv = dv_cnt_b;
    send_frame(1, 8'h96, 1'b1, CPB_B);
    idle_clks(CPB_B);
    check("t4 dv_count", dv_cnt_b - b_dv, 1);
    check("t4 latency",  last_dv_cyc_b - fall_cyc[1], LAT_B);
    check("t4 byte",     byte_b, 8'h96);

    // Random traffic: good bytes queue up in order, bad stop bits only count.
    rd        = got_b_q.size();
    b_err     = err_cnt_b;
    exp_err   = 0;
    last_good = 8'h96;
    for (int n = 0; n < 60; n++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(1, d, good, CPB_B);
      if (good) begin
        exp_q.push_back(d);
        last_good = d;
        idle_clks($urandom_range(0, 2) * CPB_B);
      end else begin
        exp_err++;
        idle_clks($urandom_range(0, 10));
        drive_line(1, 1'b1);
        idle_clks(CPB_B + $urandom_range(0, 4));
      end
    end
    idle_clks(2 * CPB_B);
    check("rand dv_count",  got_b_q.size() - rd, exp_q.size());
    check("rand err_count", err_cnt_b - b_err,   exp_err);
    check("rand last_byte", byte_b,              last_good);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("rand byte%0d", k), got_b_at(rd + k), e);
      k++;
    end

    // Strobes were never wider than one cycle nor simultaneous.
    check("pulse_rules_a", viol_a, 0);
    check("pulse_rules_b", viol_b, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmitter, consuming the 8N1 stream it drives on `o_TX_Serial`. It synchronises the asynchronous line, detects and validates the start bit, and samples each bit at mid-period. Each received byte is delivered as a one-cycle valid strobe; framing errors are flagged separately. It shares the `wb_clk_i`-derived `i_Clock` and the bit-rate parameter of the transmitter.

## Interface
- `CLKS_PER_BIT`, 217, clocks per serial bit; legal range 4..65535.
- `i_Clock` input 1: sole clock, rising edge.
- `i_Reset_n` input 1: reset, asynchronous and active-low.
- `i_RX_Serial` input 1: serial line; idles high and is asynchronous to `i_Clock`.
- `o_RX_DV` output 1: one-cycle pulse when `o_RX_Byte` holds a newly received good byte.
- `o_RX_Byte` output 8: last good byte, LSB first on the wire; held between frames.
- `o_RX_Frame_Err` output 1: one-cycle pulse when the stop bit samples low.
- `o_RX_Active` output 1: high from start-bit qualification until the stop-bit sample.

## Operation
- **Reset values:** all outputs 0; synchroniser flops 1; state IDLE; counters 0.
- **Synchroniser:** 2-flop synchroniser; `rx_s` is the synchronised line, used exclusively. Constants: HALF = CLKS_PER_BIT/2 (integer division); counter width = $clog2(CLKS_PER_BIT).
- **IDLE:** clear the counter and bit index. If `rx_s`==0, go to START.
- **START:** increment the counter until it reaches HALF-1. At that point, `rx_s`==0 goes to DATA with the counter cleared and `o_RX_Active` set; `rx_s`==1 is a glitch and returns to IDLE with no output.
- **DATA:** at counter == CLKS_PER_BIT-1, shift `rx_s` into shift[bit_index], clear the counter and increment bit_index (3-bit). After index 7 is sampled, go to STOP.
- **STOP:** at counter == CLKS_PER_BIT-1, clear `o_RX_Active`.
  - `rx_s`==1: load `o_RX_Byte` from the shift register, pulse `o_RX_DV`, go to CLEANUP.
  - `rx_s`==0: pulse `o_RX_Frame_Err`, leave `o_RX_Byte` unchanged, go to WAIT_IDLE.
- **CLEANUP:** one cycle, then IDLE.
- **WAIT_IDLE:** remain until `rx_s`==1, then IDLE. A break or stuck-low line produces exactly one error pulse.
- `o_RX_DV` and `o_RX_Frame_Err` are mutually exclusive and never assert for more than one cycle.
- Reset asserted mid-frame aborts immediately. The partial byte is discarded, no pulse is generated, and reception restarts at the next falling edge after release.

## Timing
- Cycle 0 is the first edge at which IDLE sees `rx_s`==0 (2–3 clocks after the pin falls).
- START qualification check: cycle HALF. Data bit k is sampled at cycle HALF + (k+1)·CLKS_PER_BIT. The stop bit is sampled at HALF + 9·CLKS_PER_BIT.
- `o_RX_DV` / `o_RX_Frame_Err` are high during cycle HALF + 9·CLKS_PER_BIT + 1, which is 2062 for the default.
- Back-to-back frames: IDLE is re-entered about CLKS_PER_BIT/2 before the stop bit ends, so a start bit immediately following the stop bit is caught with no lost frame.
- No backpressure: the consumer must take `o_RX_Byte` within one frame time, because the next good byte overwrites it.

## Structure
- Shared package `uart_pkg`:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4, WAIT_IDLE=5 as 3-bit constants, shared with the transmitter;
  - default CLKS_PER_BIT=217.
- One natural sub-module: `uart_sync2`, a 2-flop synchroniser with parameterised reset value 1 and async active-low reset.
- Loopback bench top: instantiate the transmitter and `uart_rx` with the serial line tied together.

## Test plan
- **Loopback 0xA5:** TX sends 0xA5 → exactly one `o_RX_DV` with `o_RX_Byte`=0xA5, no `o_RX_Frame_Err`; repeat for 0x00, 0xFF, 0x01, 0x80.
- **Back-to-back:** 0x55 then 0x3C driven with zero idle between stop and start bits → two `o_RX_DV` pulses 10·217 clocks apart, bytes 0x55 then 0x3C.
- **Glitch:** line low for 50 clocks then high → state returns to IDLE, `o_RX_Active` never rises, no pulses.
- **Framing error:** drive byte 0x12 with stop bit 0, line held low 3000 clocks → one `o_RX_Frame_Err`, `o_RX_Byte` keeps its prior value; then a good 0x34 → `o_RX_DV` with 0x34.
- **Reset mid-frame:** assert `i_Reset_n`=0 during data bit 4 → all outputs 0 immediately; after release the next frame 0xC3 is received correctly.
- **Timing check:** with CLKS_PER_BIT=4, `o_RX_DV` rises exactly at cycle 2+9·4+1=39 after the synchronised falling edge.
